// File: rtl/add_seq_ctrl.sv
`default_nettype none
// ============================================================================
// add_seq_ctrl : sequences one bit-serial WIDTH-bit add and commits the result
// Revision     : 1.0
// ============================================================================
module add_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int CW    = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Run,
    input  logic          Clear,
    output logic          Shift_En,
    output logic          Carry_Clr,
    output logic [CW-1:0] Bit_Idx,
    output logic          Load,
    output logic          Reg_Clr,
    output logic          Busy,
    output logic          Done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SHIFT = 3'd2,
        S_LOAD  = 3'd3,
        S_HOLD  = 3'd4,
        S_ZERO  = 3'd5
    } state_t;

    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                // Run has priority over Clear when both arrive together
                if (Run)        state_d = S_CLEAR;
                else if (Clear) state_d = S_ZERO;
            end
            S_CLEAR: begin
                state_d = S_SHIFT;
                cnt_d   = '0;
            end
            S_SHIFT: begin
                if (cnt_q == C_LAST) state_d = S_LOAD;
                else                 cnt_d   = cnt_q + 1'b1;
            end
            S_LOAD:  state_d = S_HOLD;
            // One press yields one add: Run must drop before re-arming
            S_HOLD:  if (!Run)   state_d = S_IDLE;
            S_ZERO:  if (!Clear) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        Shift_En  = (state_q == S_SHIFT);
        Carry_Clr = (state_q == S_CLEAR);
        Load      = (state_q == S_LOAD);
        Reg_Clr   = (state_q == S_ZERO);
        Done      = (state_q == S_HOLD);
        Busy      = (state_q == S_CLEAR) || (state_q == S_SHIFT) || (state_q == S_LOAD);
        Bit_Idx   = (state_q == S_SHIFT) ? cnt_q : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_add_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_add_seq_ctrl : checks add_seq_ctrl against a cycle-offset timing model
// Revision        : 1.0
// ============================================================================
module tb_add_seq_ctrl;

    localparam int WIDTH = 16;
    localparam int CW    = 4;

    logic          Clk;
    logic          Reset;
    logic          Run;
    logic          Clear;
    logic          Shift_En;
    logic          Carry_Clr;
    logic [CW-1:0] Bit_Idx;
    logic          Load;
    logic          Reg_Clr;
    logic          Busy;
    logic          Done;

    add_seq_ctrl #(.WIDTH(WIDTH), .CW(CW)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Run       (Run),
        .Clear     (Clear),
        .Shift_En  (Shift_En),
        .Carry_Clr (Carry_Clr),
        .Bit_Idx   (Bit_Idx),
        .Load      (Load),
        .Reg_Clr   (Reg_Clr),
        .Busy      (Busy),
        .Done      (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    int loads  = 0;

    // Model: an add is described only by the number of edges since Run was
    // accepted; expected outputs follow from the documented cycle offsets.
    int mode = 0;   // 0 = quiet, 1 = add in progress/holding, 2 = clearing
    int off  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic c, input logic rs);
        logic e_sh, e_cc, e_ld, e_rc, e_bz, e_dn;
        int   e_ix;
        Run   = r;
        Clear = c;
        Reset = rs;
        @(posedge Clk);
        if (rs) begin
            mode = 0;
        end else begin
            case (mode)
                0: begin
                    if (r) begin
                        mode = 1;
                        off  = 1;
                    end else if (c) begin
                        mode = 2;
                    end
                end
                1: begin
                    if (off >= WIDTH + 3 && !r) mode = 0;
                    else if (off < WIDTH + 3)   off++;
                end
                default: if (!c) mode = 0;
            endcase
        end
        e_cc = (mode == 1) && (off == 1);
        e_sh = (mode == 1) && (off >= 2) && (off <= WIDTH + 1);
        e_ix = e_sh ? off - 2 : 0;
        e_ld = (mode == 1) && (off == WIDTH + 2);
        e_dn = (mode == 1) && (off >= WIDTH + 3);
        e_bz = (mode == 1) && (off <= WIDTH + 2);
        e_rc = (mode == 2);
        #1;
        if (Load === 1'b1) loads++;
        chk("Shift_En",  {31'd0, Shift_En},  {31'd0, e_sh});
        chk("Carry_Clr", {31'd0, Carry_Clr}, {31'd0, e_cc});
        chk("Bit_Idx",   {28'd0, Bit_Idx},   32'(e_ix));
        chk("Load",      {31'd0, Load},      {31'd0, e_ld});
        chk("Reg_Clr",   {31'd0, Reg_Clr},   {31'd0, e_rc});
        chk("Busy",      {31'd0, Busy},      {31'd0, e_bz});
        chk("Done",      {31'd0, Done},      {31'd0, e_dn});
    endtask

    initial begin
        logic r, c, rs;
        Run = 1'b0; Clear = 1'b0; Reset = 1'b1;

        // Reset then idle
        repeat (2) cyc(1'b0, 1'b0, 1'b1);
        repeat (5) cyc(1'b0, 1'b0, 1'b0);

        // Run held 40 cycles: exactly one Load
        loads = 0;
        repeat (40) cyc(1'b1, 1'b0, 1'b0);
        repeat (3)  cyc(1'b0, 1'b0, 1'b0);
        chk("load_count_held", 32'(loads), 32'd1);

        // One-cycle Run, Reset mid-SHIFT: no Load ever
        loads = 0;
        cyc(1'b1, 1'b0, 1'b0);
        repeat (9)  cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        repeat (20) cyc(1'b0, 1'b0, 1'b0);
        chk("load_count_reset", 32'(loads), 32'd0);

        // Clear in IDLE, then Clear pulsed during SHIFT
        repeat (4) cyc(1'b0, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 1'b0);
        repeat (WIDTH + 2) cyc(1'b0, 1'b0, 1'b0);

        // Run and Clear together: the add wins
        repeat (WIDTH + 4) cyc(1'b1, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);

        // Two presses, one-cycle low in HOLD
        loads = 0;
        repeat (WIDTH + 5) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        repeat (WIDTH + 5) cyc(1'b1, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        chk("load_count_two", 32'(loads), 32'd2);

        // Randomised level activity with occasional reset
        r = 1'b0; c = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) r = ~r;
            if ($urandom_range(0, 5) == 0) c = ~c;
            rs = ($urandom_range(0, 199) == 0);
            cyc(r, c, rs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
